crc32_frame_checker: RTL and testbench
======================================

// Module: crc32_frame_checker
// PURPOSE
//  Receive-side counterpart of the CRC32 generator peripheral: consumes a byte stream (payload + 4-byte CRC trailer),
//  recomputes CRC32 over the payload bit-serially, compares it against the trailer and reports pass/fail per frame.
//  Sits behind the TinyQV register wrapper, which feeds s_* from a data register and exposes results and counters.
// PARAMETERS
//  DEFAULT_POLY  32'h04C11DB7  polynomial used when poly input is 0
//  CNT_W         8             width of good/bad frame counters (saturating)
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      reset
//  poly       in   32     generator polynomial, normal (non-reflected) form
//  cfg_refin  in   1      1 = bytes processed LSB-first and final CRC bit-reversed (refout = refin)
//  cfg_xorout in   1      1 = final CRC XOR 32'hFFFFFFFF
//  cfg_init   in   1      1 = CRC register starts at 32'hFFFFFFFF, 0 = 32'h0
//  cfg_tmsb   in   1      trailer byte order: 0 = CRC LSB byte first, 1 = MSB byte first
//  s_data     in   8      stream byte
//  s_valid    in   1      s_data valid
//  s_last     in   1      s_data is the final trailer byte of the frame
//  s_ready    out  1      block accepts a byte on this cycle's edge when s_valid & s_ready
//  abort      in   1      discard current frame
//  busy       out  1      frame in progress (state != IDLE)
//  res_valid  out  1      one-cycle pulse: result fields updated
//  res_ok     out  1      last frame passed (held until next result)
//  crc_calc   out  32     final computed CRC of last frame
//  crc_rx     out  32     trailer value of last frame
//  good_cnt   out  CNT_W  passed frames, saturating
//  bad_cnt    out  CNT_W  failed frames (incl. runts), saturating
// BEHAVIOUR
//  Clocking: one clock; reset is synchronous and active-low (rst_n sampled on clk rising edge).
//  Reset: state IDLE, window/fill/crc cleared, all outputs 0 (s_ready=0 while rst_n=0, 1 the first cycle after).
//  Window: 4-byte delay line, fill 0..4; the 4 most recent bytes are always held back as candidate trailer.
//  FSM: IDLE -> ACCEPT -> SHIFT -> CHECK -> IDLE.
//   IDLE: s_ready=1; on first accept latch poly(0 -> DEFAULT_POLY), cfg_* for whole frame; crc=init; -> ACCEPT.
//    Config changes mid-frame are ignored.
//   ACCEPT: s_ready=1. Accept with fill<4: push, fill++. Accept with fill==4: oldest byte -> engine, new byte pushed,
//    -> SHIFT. Accept with s_last: go SHIFT if a byte was popped, else CHECK.
//   SHIFT: s_ready=0, exactly 8 cycles, one bit per cycle (bit7 first if refin=0, bit0 first if refin=1);
//    step: fb=crc[31]^bit; crc={crc[30:0],1'b0} ^ (fb ? poly : 0). Then -> ACCEPT, or CHECK if s_last was taken.
//   CHECK: 1 cycle; calc = (refin ? bitrev(crc) : crc) ^ (xorout ? 32'hFFFFFFFF : 0);
//    rx assembled from window per cfg_tmsb; runt = fill<4 at s_last (fewer than 4 bytes total).
//    res_ok = !runt && calc==rx; runt -> crc_rx=0. Register outputs, bump one counter, -> IDLE.
//  Latency: last byte accepted at edge 0 with pop -> SHIFT cycles 1-8, CHECK 9, res_valid high in cycle 10.
//   Without pop (4-byte frame or runt): CHECK cycle 1, res_valid cycle 2. Throughput: 1 payload byte / 9 cycles.
//  Zero-length payload (exactly 4 bytes) is legal: calc is CRC of empty message.
//  abort (priority over everything but reset): -> IDLE same edge, window/fill cleared, no res_valid, counters kept;
//   a byte offered with abort high is not accepted.
//  Counters saturate at all-ones; res_ok/crc_* hold until next CHECK.
//  Reset mid-SHIFT: frame silently dropped, outputs return to reset values.
// STRUCTURE
//  crc_defs.vh: state encodings, CRC32_DEFAULT_POLY, CRC32_ALL_ONES, check constants used by bench.
//  Sub-module crc32_bit_engine: 32-bit register, load init, 1-bit step with poly; FSM/window/counters stay top-level.
// TESTING
//  "123456789", refin=1 xorout=1 init=1 tmsb=0, trailer 26 39 F4 CB -> res_ok=1, crc_calc=0xCBF43926, good_cnt=1.
//  Same frame, trailer 26 39 F4 CA -> res_ok=0, crc_rx=0xCAF43926, bad_cnt=1.
//  "123456789", refin=0 xorout=1 tmsb=1, trailer FC 89 19 18 -> ok, 0xFC891918; xorout=0 trailer 03 76 E6 E7 -> ok, 0x0376E6E7.
//  3-byte frame with s_last -> res_valid exactly cycle 2, res_ok=0, bad_cnt++; 4-byte frame 00 00 00 00 (refin=1,xorout=1,init=1) -> ok.
//  Random s_valid gaps, abort after byte 5, rst_n low during SHIFT -> no res_valid, next frame checks correctly, s_ready low 8 cycles per pop.
//  256 good frames with CNT_W=8 -> good_cnt sticks at 255; res_valid timing = 10 cycles after last-byte accept.

Source files
------------

// File: rtl/crc32_frame_checker_pkg.sv
// Shared types and constants for the CRC32 frame checker.
package crc32_frame_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_SHIFT,
        ST_CHECK
    } state_e;

    localparam logic [31:0] CRC32_DEFAULT_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC32_ALL_ONES     = 32'hFFFFFFFF;

    // Well-known check values of "123456789" for the supported CRC32 flavours.
    localparam logic [31:0] CRC32_CHECK_REFLECTED = 32'hCBF43926;
    localparam logic [31:0] CRC32_CHECK_BZIP2     = 32'hFC891918;
    localparam logic [31:0] CRC32_CHECK_MPEG2     = 32'h0376E6E7;

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_frame_checker_if.sv
// Byte-stream handshake carrying payload plus CRC trailer into the checker.
interface crc32_frame_checker_if;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (output s_data, output s_valid, output s_last, input s_ready);
    modport slave  (input s_data, input s_valid, input s_last, output s_ready);

endinterface

// File: rtl/crc32_frame_checker_bit_engine.sv
// Bit-serial CRC32 register: loads an initial value and advances one message bit per step.
module crc32_bit_engine (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] initVal_i,
    input  logic        step_i,
    input  logic        bit_i,
    input  logic [31:0] poly_i,
    output logic [31:0] crc_o
);

    logic [31:0] crcReg_q;
    logic        feedback;

    assign feedback = crcReg_q[31] ^ bit_i;
    assign crc_o    = crcReg_q;

    // CRC register: load wins over step, one polynomial division step per enabled cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crcReg_q <= '0;
        end else if (load_i) begin
            crcReg_q <= initVal_i;
        end else if (step_i) begin
            crcReg_q <= {crcReg_q[30:0], 1'b0} ^ (feedback ? poly_i : 32'h0);
        end
    end

endmodule

// File: rtl/crc32_frame_checker.sv
// Receive-side CRC32 checker: holds back the last 4 bytes as trailer, feeds older bytes
// bit-serially into the CRC engine and reports pass/fail plus saturating frame counters.
module crc32_frame_checker
    import crc32_frame_checker_pkg::*;
#(
    parameter logic [31:0] DEFAULT_POLY = CRC32_DEFAULT_POLY,
    parameter int          CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    crc32_frame_checker_if.slave strm,
    input  logic [31:0]        poly_i,
    input  logic               cfg_refin_i,
    input  logic               cfg_xorout_i,
    input  logic               cfg_init_i,
    input  logic               cfg_tmsb_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic               res_valid_o,
    output logic               res_ok_o,
    output logic [31:0]        crc_calc_o,
    output logic [31:0]        crc_rx_o,
    output logic [CNT_W-1:0]   good_cnt_o,
    output logic [CNT_W-1:0]   bad_cnt_o
);

    state_e             state_q, state_d;
    logic [2:0]         fill_q, fill_d;
    logic [31:0]        window_q, window_d;
    logic [7:0]         popByte_q, popByte_d;
    logic [2:0]         bitCnt_q, bitCnt_d;
    logic               lastSeen_q, lastSeen_d;
    logic [31:0]        polyReg_q, polyReg_d;
    logic               refin_q, refin_d;
    logic               xorout_q, xorout_d;
    logic               tmsb_q, tmsb_d;
    logic               resValid_q, resValid_d;
    logic               resOk_q, resOk_d;
    logic [31:0]        crcCalc_q, crcCalc_d;
    logic [31:0]        crcRx_q, crcRx_d;
    logic [CNT_W-1:0]   goodCnt_q, goodCnt_d;
    logic [CNT_W-1:0]   badCnt_q, badCnt_d;

    logic               accept;
    logic               engLoad;
    logic               engStep;
    logic               engBit;
    logic [31:0]        engCrc;
    logic [31:0]        calcCrc;
    logic [31:0]        rxCrc;
    logic               runt;

    // Oldest window byte is the first trailer byte; tmsb selects which end of the CRC it carries.
    assign rxCrc   = tmsb_q ? window_q
                            : {window_q[7:0], window_q[15:8], window_q[23:16], window_q[31:24]};
    assign calcCrc = (refin_q ? bitrev32(engCrc) : engCrc) ^ (xorout_q ? CRC32_ALL_ONES : 32'h0);
    assign runt    = (fill_q != 3'd4);

    assign strm.s_ready = rst_n && !abort_i && (state_q == ST_IDLE || state_q == ST_ACCEPT);
    assign accept       = strm.s_valid && strm.s_ready;

    assign busy_o      = rst_n && (state_q != ST_IDLE);
    assign res_valid_o = resValid_q;
    assign res_ok_o    = resOk_q;
    assign crc_calc_o  = crcCalc_q;
    assign crc_rx_o    = crcRx_q;
    assign good_cnt_o  = goodCnt_q;
    assign bad_cnt_o   = badCnt_q;

    crc32_bit_engine u_engine (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (engLoad),
        .initVal_i (cfg_init_i ? CRC32_ALL_ONES : 32'h0),
        .step_i    (engStep),
        .bit_i     (engBit),
        .poly_i    (polyReg_q),
        .crc_o     (engCrc)
    );

    // Frame FSM: window management, bit shifting, result check; abort overrides everything.
    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        window_d   = window_q;
        popByte_d  = popByte_q;
        bitCnt_d   = bitCnt_q;
        lastSeen_d = lastSeen_q;
        polyReg_d  = polyReg_q;
        refin_d    = refin_q;
        xorout_d   = xorout_q;
        tmsb_d     = tmsb_q;
        resValid_d = 1'b0;
        resOk_d    = resOk_q;
        crcCalc_d  = crcCalc_q;
        crcRx_d    = crcRx_q;
        goodCnt_d  = goodCnt_q;
        badCnt_d   = badCnt_q;
        engLoad    = 1'b0;
        engStep    = 1'b0;
        engBit     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    polyReg_d = (poly_i == 32'h0) ? DEFAULT_POLY : poly_i;
                    refin_d   = cfg_refin_i;
                    xorout_d  = cfg_xorout_i;
                    tmsb_d    = cfg_tmsb_i;
                    engLoad   = 1'b1;
                    window_d  = {window_q[23:0], strm.s_data};
                    fill_d    = 3'd1;
                    state_d   = strm.s_last ? ST_CHECK : ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (accept) begin
                    window_d = {window_q[23:0], strm.s_data};
                    if (fill_q == 3'd4) begin
                        popByte_d  = window_q[31:24];
                        bitCnt_d   = 3'd0;
                        lastSeen_d = strm.s_last;
                        state_d    = ST_SHIFT;
                    end else begin
                        fill_d = fill_q + 3'd1;
                        if (strm.s_last) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
            end
            ST_SHIFT: begin
                engStep  = 1'b1;
                engBit   = refin_q ? popByte_q[bitCnt_q] : popByte_q[3'd7 - bitCnt_q];
                bitCnt_d = bitCnt_q + 3'd1;
                if (bitCnt_q == 3'd7) begin
                    state_d = lastSeen_q ? ST_CHECK : ST_ACCEPT;
                end
            end
            ST_CHECK: begin
                resValid_d = 1'b1;
                resOk_d    = !runt && (calcCrc == rxCrc);
                crcCalc_d  = calcCrc;
                crcRx_d    = runt ? 32'h0 : rxCrc;
                if (!runt && (calcCrc == rxCrc)) begin
                    if (goodCnt_q != {CNT_W{1'b1}}) goodCnt_d = goodCnt_q + 1'b1;
                end else begin
                    if (badCnt_q != {CNT_W{1'b1}}) badCnt_d = badCnt_q + 1'b1;
                end
                fill_d  = 3'd0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort_i) begin
            state_d    = ST_IDLE;
            fill_d     = 3'd0;
            window_d   = 32'h0;
            resValid_d = 1'b0;
            resOk_d    = resOk_q;
            crcCalc_d  = crcCalc_q;
            crcRx_d    = crcRx_q;
            goodCnt_d  = goodCnt_q;
            badCnt_d   = badCnt_q;
            engLoad    = 1'b0;
            engStep    = 1'b0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fill_q     <= '0;
            window_q   <= '0;
            popByte_q  <= '0;
            bitCnt_q   <= '0;
            lastSeen_q <= 1'b0;
            polyReg_q  <= '0;
            refin_q    <= 1'b0;
            xorout_q   <= 1'b0;
            tmsb_q     <= 1'b0;
            resValid_q <= 1'b0;
            resOk_q    <= 1'b0;
            crcCalc_q  <= '0;
            crcRx_q    <= '0;
            goodCnt_q  <= '0;
            badCnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            window_q   <= window_d;
            popByte_q  <= popByte_d;
            bitCnt_q   <= bitCnt_d;
            lastSeen_q <= lastSeen_d;
            polyReg_q  <= polyReg_d;
            refin_q    <= refin_d;
            xorout_q   <= xorout_d;
            tmsb_q     <= tmsb_d;
            resValid_q <= resValid_d;
            resOk_q    <= resOk_d;
            crcCalc_q  <= crcCalc_d;
            crcRx_q    <= crcRx_d;
            goodCnt_q  <= goodCnt_d;
            badCnt_q   <= badCnt_d;
        end
    end

endmodule

// File: tb/tb_crc32_frame_checker.sv
// Directed testbench for crc32_frame_checker using published CRC32 check values.
module tb_crc32_frame_checker;
    import crc32_frame_checker_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] poly;
    logic        cfgRefin;
    logic        cfgXorout;
    logic        cfgInit;
    logic        cfgTmsb;
    logic        abort;
    logic        busy;
    logic        resValid;
    logic        resOk;
    logic [31:0] crcCalc;
    logic [31:0] crcRx;
    logic [7:0]  goodCnt;
    logic [7:0]  badCnt;

    int          checkCount;
    int          failCount;
    logic [7:0]  frameQ[$];
    int          waitArr[64];
    int          latency;

    crc32_frame_checker_if strm();

    crc32_frame_checker #(
        .DEFAULT_POLY (32'h04C11DB7),
        .CNT_W        (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .strm         (strm),
        .poly_i       (poly),
        .cfg_refin_i  (cfgRefin),
        .cfg_xorout_i (cfgXorout),
        .cfg_init_i   (cfgInit),
        .cfg_tmsb_i   (cfgTmsb),
        .abort_i      (abort),
        .busy_o       (busy),
        .res_valid_o  (resValid),
        .res_ok_o     (resOk),
        .crc_calc_o   (crcCalc),
        .crc_rx_o     (crcRx),
        .good_cnt_o   (goodCnt),
        .bad_cnt_o    (badCnt)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Offers one byte after 'gap' idle cycles; returns how many cycles s_ready stayed low.
    task automatic applyStimulus(input logic [7:0] d, input logic last, input int gap, output int waited);
        logic ready;
        logic accepted;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        strm.s_data  = d;
        strm.s_last  = last;
        strm.s_valid = 1'b1;
        waited       = 0;
        accepted     = 1'b0;
        while (!accepted && waited < 100) begin
            @(negedge clk);
            ready = strm.s_ready;
            @(posedge clk);
            #1;
            if (ready) accepted = 1'b1;
            else       waited++;
        end
        strm.s_valid = 1'b0;
        strm.s_last  = 1'b0;
        if (!accepted) checkOutput("ready_timeout", {31'b0, strm.s_ready}, 32'h1);
    endtask

    task automatic sendBytes(input int count, input logic withLast, input int maxGap);
        int w;
        int gap;
        for (int i = 0; i < count; i++) begin
            gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
            applyStimulus(frameQ[i], withLast && (i == count - 1), gap, w);
            if (i < 64) waitArr[i] = w;
        end
    endtask

    // Counts cycles from the last accept until res_valid, then checks it is a single pulse.
    task automatic waitResult(output int lat);
        logic got;
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (resValid) begin
                lat = k;
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("res_valid_pulse", {31'b0, resValid}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic watchQuiet(input string tag, input int n);
        int seen;
        seen = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (resValid) seen++;
        end
        @(posedge clk);
        #1;
        checkOutput(tag, seen, 0);
    endtask

    task automatic loadFrame(input string s, input logic [31:0] trailer);
        frameQ.delete();
        for (int i = 0; i < s.len(); i++) frameQ.push_back(s[i]);
        frameQ.push_back(trailer[31:24]);
        frameQ.push_back(trailer[23:16]);
        frameQ.push_back(trailer[15:8]);
        frameQ.push_back(trailer[7:0]);
    endtask

    task automatic setCfg(input logic [31:0] p, input logic ri, input logic xo, input logic ini, input logic tm);
        poly      = p;
        cfgRefin  = ri;
        cfgXorout = xo;
        cfgInit   = ini;
        cfgTmsb   = tm;
    endtask

    initial begin
        checkCount   = 0;
        failCount    = 0;
        rst_n        = 1'b0;
        abort        = 1'b0;
        strm.s_data  = 8'h00;
        strm.s_valid = 1'b0;
        strm.s_last  = 1'b0;
        setCfg(32'h0, 1'b1, 1'b1, 1'b1, 1'b0);

        // Reset behaviour
        @(negedge clk);
        checkOutput("rst_s_ready", {31'b0, strm.s_ready}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_s_ready_after", {31'b0, strm.s_ready}, 32'h1);
        checkOutput("rst_busy", {31'b0, busy}, 32'h0);
        checkOutput("rst_outputs", {resValid, resOk, goodCnt, badCnt}, 32'h0);
        checkOutput("rst_crc_calc", crcCalc, 32'h0);
        @(posedge clk);
        #1;

        // Standard reflected CRC32, default poly via poly=0, trailer LSB first
        loadFrame("123456789", 32'h2639F4CB);
        sendBytes(frameQ.size(), 1'b1, 0);
        waitResult(latency);
        checkOutput("std_latency", latency, 10);
        checkOutput("std_stall", waitArr[5], 8);
        checkOutput("std_ok", {31'b0, resOk}, 32'h1);
        checkOutput("std_calc", crcCalc, CRC32_CHECK_REFLECTED);
        checkOutput("std_rx", crcRx, 32'hCBF43926);
        checkOutput("std_good", goodCnt, 1);

        // Corrupted trailer
        loadFrame("123456789", 32'h2639F4CA);
        sendBytes(frameQ.size(), 1'b1, 0);
        waitResult(latency);
        checkOutput("bad_ok", {31'b0, resOk}, 32'h0);
        checkOutput("bad_rx", crcRx, 32'hCAF43926);
        checkOutput("bad_calc", crcCalc, 32'hCBF43926);
        checkOutput("bad_cnt", badCnt, 1);

        // Non-reflected, MSB-first trailer, random gaps
        setCfg(32'h04C11DB7, 1'b0, 1'b1, 1'b1, 1'b1);
        loadFrame("123456789", 32'hFC891918);
        sendBytes(frameQ.size(), 1'b1, 2);
        waitResult(latency);
        checkOutput("bzip2_ok", {31'b0, resOk}, 32'h1);
        checkOutput("bzip2_calc", crcCalc, CRC32_CHECK_BZIP2);

        // Same without final XOR
        setCfg(32'h04C11DB7, 1'b0, 1'b0, 1'b1, 1'b1);
        loadFrame("123456789", 32'h0376E6E7);
        sendBytes(frameQ.size(), 1'b1, 1);
        waitResult(latency);
        checkOutput("mpeg2_ok", {31'b0, resOk}, 32'h1);
        checkOutput("mpeg2_calc", crcCalc, CRC32_CHECK_MPEG2);
        checkOutput("mpeg2_good", goodCnt, 3);

        // Runt frame of 3 bytes
        setCfg(32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        frameQ.delete();
        frameQ.push_back(8'h61);
        frameQ.push_back(8'h62);
        frameQ.push_back(8'h63);
        sendBytes(3, 1'b1, 0);
        waitResult(latency);
        checkOutput("runt_latency", latency, 2);
        checkOutput("runt_ok", {31'b0, resOk}, 32'h0);
        checkOutput("runt_rx", crcRx, 32'h0);
        checkOutput("runt_bad", badCnt, 2);

        // Empty payload: CRC of empty message is 0
        loadFrame("", 32'h00000000);
        sendBytes(4, 1'b1, 0);
        waitResult(latency);
        checkOutput("empty_latency", latency, 2);
        checkOutput("empty_ok", {31'b0, resOk}, 32'h1);
        checkOutput("empty_calc", crcCalc, 32'h0);
        checkOutput("empty_good", goodCnt, 4);

        // Abort during the first shift; counters untouched, next frame still good
        loadFrame("123456789", 32'h2639F4CB);
        sendBytes(5, 1'b0, 0);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", {31'b0, busy}, 32'h0);
        @(posedge clk);
        #1;
        watchQuiet("abort_no_result", 20);
        checkOutput("abort_counts", {goodCnt, badCnt}, {8'd4, 8'd2});
        sendBytes(frameQ.size(), 1'b1, 0);
        waitResult(latency);
        checkOutput("abort_next_ok", {31'b0, resOk}, 32'h1);
        checkOutput("abort_next_good", goodCnt, 5);

        // Reset asserted mid-shift drops the frame and clears all outputs
        sendBytes(5, 1'b0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_s_ready", {31'b0, strm.s_ready}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_outputs", {busy, resOk, goodCnt, badCnt}, 32'h0);
        @(posedge clk);
        #1;
        watchQuiet("midrst_no_result", 20);
        sendBytes(frameQ.size(), 1'b1, 0);
        waitResult(latency);
        checkOutput("midrst_next_ok", {31'b0, resOk}, 32'h1);
        checkOutput("midrst_next_good", goodCnt, 1);

        // Saturation of the good counter
        loadFrame("", 32'h00000000);
        for (int f = 0; f < 256; f++) begin
            sendBytes(4, 1'b1, 0);
            waitResult(latency);
        end
        checkOutput("sat_good", goodCnt, 255);
        checkOutput("sat_bad", badCnt, 0);

        $display("test done: total=%0d bad=%0d", checkCount, failCount);
        $finish;
    end

endmodule
